// File: rtl/crack_core.sv
// ARC4 brute-force key search over one key subrange, S-box held in an external 256x8 RAM.
// Optional build macro CRACK_ABORT_EN adds the stop input for aborting a running search.
module crack_core #(
    parameter logic [23:0] KEY_START  = 24'h000000,
    parameter logic [23:0] KEY_STRIDE = 24'd1,
    parameter logic [23:0] KEY_END    = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        rdy,
    output logic [23:0] key,
    output logic        key_valid,
    output logic [7:0]  ct_addr,
    input  logic [7:0]  ct_rddata,
    output logic [7:0]  s_addr,
    output logic [7:0]  s_wrdata,
    output logic        s_wren,
    input  logic [7:0]  s_rddata
`ifdef CRACK_ABORT_EN
    ,
    input  logic        stop
`endif
);

    // states: IDLE wait en | LEN/LEN_WT fetch L | INIT S[i]=i | RD_I..WR_J one swap (KSA or PRGA) | PAD/CHK pad+test | NEXT step key
    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] LEN    = 4'd1;
    localparam logic [3:0] LEN_WT = 4'd2;
    localparam logic [3:0] INIT   = 4'd3;
    localparam logic [3:0] RD_I   = 4'd4;
    localparam logic [3:0] RD_J   = 4'd5;
    localparam logic [3:0] WT_J   = 4'd6;
    localparam logic [3:0] GET_J  = 4'd7;
    localparam logic [3:0] WR_I   = 4'd8;
    localparam logic [3:0] WR_J   = 4'd9;
    localparam logic [3:0] PAD    = 4'd10;
    localparam logic [3:0] CHK    = 4'd11;
    localparam logic [3:0] NEXT   = 4'd12;

    logic [3:0]  state;
    logic [7:0]  i, j, si, sj, k, len;
    logic [1:0]  km;
    logic        prga;
    logic [7:0]  kb, jn, p;
    logic [24:0] next_key;

    always_comb begin
        kb = key[7:0];
        if (km == 2'd0)
            kb = key[23:16];
        else if (km == 2'd1)
            kb = key[15:8];
        jn       = j + s_rddata + (prga ? 8'd0 : kb);
        p        = s_rddata ^ ct_rddata;
        next_key = {1'b0, key} + {1'b0, KEY_STRIDE};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rdy       <= 1'b1;
            key_valid <= 1'b0;
            key       <= 24'd0;
            ct_addr   <= 8'd0;
            s_addr    <= 8'd0;
            s_wrdata  <= 8'd0;
            s_wren    <= 1'b0;
            i         <= 8'd0;
            j         <= 8'd0;
            si        <= 8'd0;
            sj        <= 8'd0;
            k         <= 8'd0;
            len       <= 8'd0;
            km        <= 2'd0;
            prga      <= 1'b0;
        end
`ifdef CRACK_ABORT_EN
        else if (stop && state != IDLE) begin
            state     <= IDLE;
            rdy       <= 1'b1;
            key_valid <= 1'b0;
            s_wren    <= 1'b0;
        end
`endif
        else begin
            case (state)
                IDLE: if (en) begin
                    rdy       <= 1'b0;
                    key_valid <= 1'b0;
                    key       <= KEY_START;
                    ct_addr   <= 8'd0;
                    state     <= LEN;
                end
                LEN: state <= LEN_WT;
                LEN_WT: begin
                    len      <= ct_rddata;
                    i        <= 8'd0;
                    s_addr   <= 8'd0;
                    s_wrdata <= 8'd0;
                    s_wren   <= 1'b1;
                    state    <= INIT;
                end
                INIT: if (i == 8'hFF) begin
                    s_wren <= 1'b0;
                    i      <= 8'd0;
                    j      <= 8'd0;
                    km     <= 2'd0;
                    prga   <= 1'b0;
                    s_addr <= 8'd0;
                    state  <= RD_I;
                end else begin
                    i        <= i + 8'd1;
                    s_addr   <= i + 8'd1;
                    s_wrdata <= i + 8'd1;
                end
                RD_I: state <= RD_J;
                RD_J: begin
                    si     <= s_rddata;
                    j      <= jn;
                    s_addr <= jn;
                    state  <= WT_J;
                end
                WT_J: state <= GET_J;
                GET_J: begin
                    sj       <= s_rddata;
                    s_addr   <= i;
                    s_wrdata <= s_rddata;
                    s_wren   <= 1'b1;
                    state    <= WR_I;
                end
                WR_I: begin
                    s_addr   <= j;
                    s_wrdata <= si;
                    state    <= WR_J;
                end
                WR_J: begin
                    s_wren <= 1'b0;
                    if (!prga) begin
                        km <= (km == 2'd2) ? 2'd0 : km + 2'd1;
                        if (i == 8'hFF) begin
                            if (len == 8'd0) begin
                                rdy       <= 1'b1;
                                key_valid <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                prga   <= 1'b1;
                                i      <= 8'd1;
                                j      <= 8'd0;
                                k      <= 8'd1;
                                s_addr <= 8'd1;
                                state  <= RD_I;
                            end
                        end else begin
                            i      <= i + 8'd1;
                            s_addr <= i + 8'd1;
                            state  <= RD_I;
                        end
                    end else begin
                        // after the swap S[i]+S[j] is still si+sj
                        s_addr  <= si + sj;
                        ct_addr <= k;
                        state   <= PAD;
                    end
                end
                PAD: state <= CHK;
                CHK: if (p < 8'h20 || p > 8'h7E) begin
                    state <= NEXT;
                end else if (k == len) begin
                    rdy       <= 1'b1;
                    key_valid <= 1'b1;
                    state     <= IDLE;
                end else begin
                    k      <= k + 8'd1;
                    i      <= i + 8'd1;
                    s_addr <= i + 8'd1;
                    state  <= RD_I;
                end
                NEXT: if (next_key > {1'b0, KEY_END}) begin
                    rdy       <= 1'b1;
                    key_valid <= 1'b0;
                    state     <= IDLE;
                end else begin
                    key      <= next_key[23:0];
                    i        <= 8'd0;
                    s_addr   <= 8'd0;
                    s_wrdata <= 8'd0;
                    s_wren   <= 1'b1;
                    ct_addr  <= 8'd0;
                    state    <= INIT;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crack_core.sv
// Directed bench for crack_core: three parameterisations run side by side with their own RAMs,
// expected keys come from a behavioural ARC4 model and a linear key-search model.
module tb_crack_core;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        en        [3];
    logic        rdy       [3];
    logic [23:0] key       [3];
    logic        key_valid [3];
    logic [7:0]  ct_addr   [3];
    logic [7:0]  ct_q      [3];
    logic [7:0]  s_addr    [3];
    logic [7:0]  s_wrdata  [3];
    logic        s_wren    [3];
    logic [7:0]  s_q       [3];
`ifdef CRACK_ABORT_EN
    logic        stop      [3];
`endif

    logic [7:0] ct_mem [3][256];
    logic [7:0] sbox   [3][256];
    logic [7:0] ks     [256];

    int vectors = 0;
    int miscompares = 0;

    crack_core #(.KEY_START(24'h000000), .KEY_STRIDE(24'd1), .KEY_END(24'h000040)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en[0]), .rdy(rdy[0]), .key(key[0]), .key_valid(key_valid[0]),
        .ct_addr(ct_addr[0]), .ct_rddata(ct_q[0]), .s_addr(s_addr[0]), .s_wrdata(s_wrdata[0]),
        .s_wren(s_wren[0]), .s_rddata(s_q[0])
`ifdef CRACK_ABORT_EN
        , .stop(stop[0])
`endif
    );
    crack_core #(.KEY_START(24'h000000), .KEY_STRIDE(24'd1), .KEY_END(24'h000010)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en[1]), .rdy(rdy[1]), .key(key[1]), .key_valid(key_valid[1]),
        .ct_addr(ct_addr[1]), .ct_rddata(ct_q[1]), .s_addr(s_addr[1]), .s_wrdata(s_wrdata[1]),
        .s_wren(s_wren[1]), .s_rddata(s_q[1])
`ifdef CRACK_ABORT_EN
        , .stop(stop[1])
`endif
    );
    crack_core #(.KEY_START(24'h000001), .KEY_STRIDE(24'd2), .KEY_END(24'h000040)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en[2]), .rdy(rdy[2]), .key(key[2]), .key_valid(key_valid[2]),
        .ct_addr(ct_addr[2]), .ct_rddata(ct_q[2]), .s_addr(s_addr[2]), .s_wrdata(s_wrdata[2]),
        .s_wren(s_wren[2]), .s_rddata(s_q[2])
`ifdef CRACK_ABORT_EN
        , .stop(stop[2])
`endif
    );

    always_ff @(posedge clk) begin
        for (int u = 0; u < 3; u++) begin
            ct_q[u] <= ct_mem[u][ct_addr[u]];
            s_q[u]  <= sbox[u][s_addr[u]];
            if (s_wren[u])
                sbox[u][s_addr[u]] <= s_wrdata[u];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic gen_ks(input logic [23:0] k, input int n);
        logic [7:0] s [256];
        logic [7:0] kb [3];
        logic [7:0] i, j, t;
        kb[0] = k[23:16];
        kb[1] = k[15:8];
        kb[2] = k[7:0];
        for (int x = 0; x < 256; x++) s[x] = x[7:0];
        j = 8'd0;
        for (int x = 0; x < 256; x++) begin
            i = x[7:0];
            j = j + s[i] + kb[x % 3];
            t = s[i]; s[i] = s[j]; s[j] = t;
        end
        i = 8'd0;
        j = 8'd0;
        for (int x = 1; x <= n; x++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i]; s[i] = s[j]; s[j] = t;
            t = s[i] + s[j];
            ks[x] = s[t];
        end
    endtask

    task automatic load_ct(input int u, input logic [23:0] k, input string msg);
        int n;
        n = msg.len();
        gen_ks(k, n);
        ct_mem[u][0] = n[7:0];
        for (int x = 1; x <= n; x++) ct_mem[u][x] = msg[x-1] ^ ks[x];
    endtask

    task automatic model_ok(input int u, input logic [23:0] k, output bit ok);
        int n;
        logic [7:0] p;
        n = int'(ct_mem[u][0]);
        gen_ks(k, n);
        ok = 1'b1;
        for (int x = 1; x <= n; x++) begin
            p = ks[x] ^ ct_mem[u][x];
            if (ok && (p < 8'h20 || p > 8'h7E)) ok = 1'b0;
        end
    endtask

    task automatic model_search(input int u, input logic [24:0] start, input logic [24:0] stride,
                                input logic [24:0] last, output logic found, output logic [23:0] kout);
        logic [24:0] k;
        bit ok;
        bit done;
        k = start;
        done = 1'b0;
        found = 1'b0;
        kout = start[23:0];
        for (int g = 0; g < 4096 && !done; g++) begin
            model_ok(u, k[23:0], ok);
            kout = k[23:0];
            if (ok) begin
                found = 1'b1;
                done = 1'b1;
            end else if (k + stride > last) begin
                done = 1'b1;
            end else begin
                k = k + stride;
            end
        end
    endtask

    task automatic wait_rdy(input int u, input int budget, output int cyc);
        cyc = 0;
        while (!rdy[u] && cyc < budget) begin
            tick;
            cyc++;
        end
    endtask

    logic        exp_found [3];
    logic [23:0] exp_key   [3];
    int          c0, c1, cyc;

    initial begin
        for (int u = 0; u < 3; u++) begin
            en[u] = 1'b0;
`ifdef CRACK_ABORT_EN
            stop[u] = 1'b0;
`endif
            for (int x = 0; x < 256; x++) begin
                ct_mem[u][x] = 8'd0;
                sbox[u][x] = 8'd0;
            end
        end
        rst_n = 1'b0;
        repeat (3) tick;
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("rst_rdy%0d", u), rdy[u], 1);
            chk($sformatf("rst_kv%0d", u), key_valid[u], 0);
            chk($sformatf("rst_key%0d", u), key[u], 0);
        end
        chk("rst_wren", s_wren[0], 0);
        chk("rst_saddr", s_addr[0], 0);
        chk("rst_swrdata", s_wrdata[0], 0);
        chk("rst_ctaddr", ct_addr[0], 0);
        rst_n = 1'b1;
        tick;

        // "hi" under key 0x18 for the full and short ranges, 0x19 for the odd-key core
        load_ct(0, 24'h000018, "hi");
        load_ct(1, 24'h000018, "hi");
        load_ct(2, 24'h000019, "hi");
        model_search(0, 25'h0, 25'd1, 25'h40, exp_found[0], exp_key[0]);
        model_search(1, 25'h0, 25'd1, 25'h10, exp_found[1], exp_key[1]);
        model_search(2, 25'h1, 25'd2, 25'h40, exp_found[2], exp_key[2]);
        for (int u = 0; u < 3; u++) en[u] = 1'b1;
        tick;
        for (int u = 0; u < 3; u++) en[u] = 1'b0;
        chk("start_rdy", rdy[0], 0);
        chk("start_kv", key_valid[0], 0);
        chk("start_key_a", key[0], 24'h0);
        chk("start_key_c", key[2], 24'h1);
        cyc = 0;
        while (!(rdy[0] && rdy[1] && rdy[2]) && cyc < 60000) begin
            tick;
            cyc++;
        end
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("srch_rdy%0d", u), rdy[u], 1);
            chk($sformatf("srch_kv%0d", u), key_valid[u], exp_found[u]);
            chk($sformatf("srch_key%0d", u), key[u], exp_key[u]);
        end
        repeat (5) tick;
        chk("hold_key_a", key[0], exp_key[0]);
        chk("hold_kv_a", key_valid[0], exp_found[0]);

        // zero-length ciphertext: accepted on first pass; en while busy must not restart
        ct_mem[0][0] = 8'd0;
        en[0] = 1'b1;
        tick;
        en[0] = 1'b0;
        wait_rdy(0, 5000, c0);
        chk("l0_rdy", rdy[0], 1);
        chk("l0_kv", key_valid[0], 1);
        chk("l0_key", key[0], 24'h0);
        en[0] = 1'b1;
        tick;
        en[0] = 1'b0;
        c1 = 0;
        while (!rdy[0] && c1 < 5000) begin
            tick;
            c1++;
            en[0] = (c1 == 10 || c1 == 1000) ? 1'b1 : 1'b0;
        end
        en[0] = 1'b0;
        chk("busy_en_latency", c1, c0);
        chk("busy_en_kv", key_valid[0], 1);
        chk("busy_en_key", key[0], 24'h0);

        // reset in the middle of the first key schedule
        load_ct(0, 24'h000003, "Hello!");
        model_search(0, 25'h0, 25'd1, 25'h40, exp_found[0], exp_key[0]);
        en[0] = 1'b1;
        tick;
        en[0] = 1'b0;
        repeat (600) tick;
        chk("mid_busy", rdy[0], 0);
        rst_n = 1'b0;
        tick;
        chk("midrst_rdy", rdy[0], 1);
        chk("midrst_kv", key_valid[0], 0);
        chk("midrst_key", key[0], 24'h0);
        chk("midrst_wren", s_wren[0], 0);
        rst_n = 1'b1;
        tick;
        en[0] = 1'b1;
        tick;
        en[0] = 1'b0;
        wait_rdy(0, 20000, cyc);
        chk("rerun_rdy", rdy[0], 1);
        chk("rerun_kv", key_valid[0], exp_found[0]);
        chk("rerun_key", key[0], exp_key[0]);

`ifdef CRACK_ABORT_EN
        en[0] = 1'b1;
        tick;
        en[0] = 1'b0;
        cyc = 0;
        while (ct_addr[0] == 8'd0 && cyc < 5000) begin
            tick;
            cyc++;
        end
        chk("abort_in_prga", rdy[0], 0);
        stop[0] = 1'b1;
        tick;
        stop[0] = 1'b0;
        chk("abort_rdy", rdy[0], 1);
        chk("abort_kv", key_valid[0], 0);
        chk("abort_wren", s_wren[0], 0);
        en[0] = 1'b1;
        tick;
        en[0] = 1'b0;
        chk("abort_restart_key", key[0], 24'h0);
        chk("abort_restart_rdy", rdy[0], 0);
        wait_rdy(0, 20000, cyc);
        chk("abort_rerun_kv", key_valid[0], exp_found[0]);
        chk("abort_rerun_key", key[0], exp_key[0]);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
